sram_ctrl: RTL and testbench

// - Bridges the MEM stage's 32-bit load/store requests to the 16-bit off-chip SRAM (18-bit half-word address).
// - Splits each word access into two half-word cycles plus wait states; holds ready low meanwhile.
// - MEM stage drives ~ready onto the pipeline freeze net; this block is the sole driver of the SRAM pins.

---
 rtl/sram_ctrl_if.sv | 19 +
 rtl/sram_ctrl.sv | 150 +++++++++++++++
 tb/tb_sram_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_if.sv
// MEM-stage side of the SRAM controller: level-held load/store request and ready/read-data return.
interface sram_ctrl_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_ctrl.sv
// Splits 32-bit MEM-stage loads/stores into two 16-bit SRAM half-word cycles plus wait states.
// Optional single-entry read buffer enabled by defining SRAM_CTRL_READ_BUF_EN.
module sram_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int DATA_BASE   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  sram_ctrl_if.slave  bus,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC_LO,
    S_ACC_HI,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] c_waitLast = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t      r_state;
  logic [3:0]  r_waitCnt;
  logic [31:0] r_readData;
  logic [17:0] r_sramAddr;
  logic        r_weN;
  logic        r_dqOe;
  logic        r_isWrite;
  logic [16:0] r_idx;
  logic [31:0] r_wdata;

  logic [16:0] w_idx;
  logic [15:0] w_dqOut;
  logic        w_bufHit;
  logic [31:0] w_bufData;

  assign w_idx   = 17'((bus.address - 32'(DATA_BASE)) >> 2);
  assign w_dqOut = (r_state == S_ACC_HI) ? r_wdata[31:16] : r_wdata[15:0];

  assign SRAM_DQ   = r_dqOe ? w_dqOut : 16'bz;
  assign SRAM_ADDR = r_sramAddr;
  assign SRAM_WE_N = r_weN;
  assign SRAM_OE_N = r_dqOe;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;

  assign bus.ready     = ((r_state == S_IDLE) && !bus.wr_en && !bus.rd_en)
                       || (r_state == S_DONE) || w_bufHit;
  assign bus.read_data = w_bufHit ? w_bufData : r_readData;

  // Address, strobe and DQ-enable are registered one state ahead so they are stable for the whole access cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_waitCnt  <= '0;
      r_readData <= '0;
      r_sramAddr <= '0;
      r_weN      <= 1'b1;
      r_dqOe     <= 1'b0;
      r_isWrite  <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.wr_en || (bus.rd_en && !w_bufHit)) begin
            r_isWrite  <= bus.wr_en;
            r_idx      <= w_idx;
            r_wdata    <= bus.write_data;
            r_sramAddr <= {w_idx, 1'b0};
            r_weN      <= ~bus.wr_en;
            r_dqOe     <= bus.wr_en;
            r_state    <= S_ACC_LO;
          end else if (w_bufHit) begin
            r_readData <= w_bufData;
          end
        end
        S_ACC_LO: begin
          if (!r_isWrite) begin
            r_readData[15:0] <= SRAM_DQ;
          end
          r_sramAddr <= {r_idx, 1'b1};
          r_state    <= S_ACC_HI;
        end
        S_ACC_HI: begin
          if (!r_isWrite) begin
            r_readData[31:16] <= SRAM_DQ;
          end
          r_weN     <= 1'b1;
          r_dqOe    <= 1'b0;
          r_waitCnt <= '0;
          r_state   <= (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          if (r_waitCnt == c_waitLast) begin
            r_waitCnt <= '0;
            r_state   <= S_DONE;
          end else begin
            r_waitCnt <= r_waitCnt + 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SRAM_CTRL_READ_BUF_EN
  logic        r_bufValid;
  logic [16:0] r_bufTag;
  logic [31:0] r_bufData;

  // A completed read refills the entry; a write to the cached word keeps it coherent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bufValid <= 1'b0;
      r_bufTag   <= '0;
      r_bufData  <= '0;
    end else if (r_state == S_DONE) begin
      if (!r_isWrite) begin
        r_bufValid <= 1'b1;
        r_bufTag   <= r_idx;
        r_bufData  <= r_readData;
      end else if (r_bufValid && (r_bufTag == r_idx)) begin
        r_bufData <= r_wdata;
      end
    end
  end

  assign w_bufHit  = (r_state == S_IDLE) && bus.rd_en && !bus.wr_en
                   && r_bufValid && (r_bufTag == w_idx);
  assign w_bufData = r_bufData;
`else
  assign w_bufHit  = 1'b0;
  assign w_bufData = '0;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: default WAIT_CYCLES instance plus a WAIT_CYCLES=0 instance, each with a small SRAM model.
module tb_sram_ctrl;

  logic clk;
  logic rst;
  logic loadMem;

  wire  [15:0] dq;
  logic [17:0] sramAddr;
  logic        weN, ubN, lbN, ceN, oeN;
  logic [15:0] mem [0:63];

  wire  [15:0] dq0;
  logic [17:0] sramAddr0;
  logic        weN0, ubN0, lbN0, ceN0, oeN0;
  logic [15:0] mem0 [0:63];

  int checkCount;
  int errorCount;

  sram_ctrl_if bus ();
  sram_ctrl_if bus0 ();

  sram_ctrl #(.WAIT_CYCLES(2), .DATA_BASE(1024)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .SRAM_DQ(dq), .SRAM_ADDR(sramAddr),
    .SRAM_WE_N(weN), .SRAM_UB_N(ubN), .SRAM_LB_N(lbN), .SRAM_CE_N(ceN), .SRAM_OE_N(oeN)
  );

  sram_ctrl #(.WAIT_CYCLES(0), .DATA_BASE(1024)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .SRAM_DQ(dq0), .SRAM_ADDR(sramAddr0),
    .SRAM_WE_N(weN0), .SRAM_UB_N(ubN0), .SRAM_LB_N(lbN0), .SRAM_CE_N(ceN0), .SRAM_OE_N(oeN0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous-read SRAM models; they only drive DQ while the controller reads.
  assign dq  = (!oeN && weN)   ? mem[sramAddr[5:0]]   : 16'bz;
  assign dq0 = (!oeN0 && weN0) ? mem0[sramAddr0[5:0]] : 16'bz;

  always @(posedge clk) begin
    if (loadMem) begin
      for (int i = 0; i < 64; i++) begin
        mem[i]  <= 16'h0000;
        mem0[i] <= 16'h0000;
      end
      mem[2]  <= 16'h5678;
      mem[3]  <= 16'h1234;
      mem[6]  <= 16'hBBBB;
      mem[7]  <= 16'hCCCC;
      mem0[0] <= 16'h3333;
      mem0[1] <= 16'h4444;
    end else begin
      if (!weN)  mem[sramAddr[5:0]]   <= dq;
      if (!weN0) mem0[sramAddr0[5:0]] <= dq0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Called #1 after a rising edge; request is held from cycle 0 until ready, then dropped.
  task automatic applyStimulus(input int sel, input logic wr, input logic rd,
                               input logic [31:0] addr, input logic [31:0] data,
                               output int lat, output logic [31:0] rdata);
    lat   = -1;
    rdata = '0;
    if (sel == 0) begin
      bus.wr_en = wr; bus.rd_en = rd; bus.address = addr; bus.write_data = data;
    end else begin
      bus0.wr_en = wr; bus0.rd_en = rd; bus0.address = addr; bus0.write_data = data;
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if ((sel == 0) ? bus.ready : bus0.ready) begin
        lat   = c;
        rdata = (sel == 0) ? bus.read_data : bus0.read_data;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    if (sel == 0) begin
      bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    end else begin
      bus0.wr_en = 1'b0; bus0.rd_en = 1'b0;
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] rdata;
    logic [17:0] addrBefore;

    checkCount = 0;
    errorCount = 0;
    rst        = 1'b0;
    loadMem    = 1'b1;
    bus.wr_en  = 1'b0; bus.rd_en  = 1'b0; bus.address  = '0; bus.write_data  = '0;
    bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.address = '0; bus0.write_data = '0;

    @(posedge clk);
    #1;
    loadMem = 1'b0;
    checkOutput("rstReady",    32'(bus.ready), 32'd1);
    checkOutput("rstWeN",      32'(weN), 32'd1);
    checkOutput("rstOeN",      32'(oeN), 32'd0);
    checkOutput("rstAddr",     32'(sramAddr), 32'd0);
    checkOutput("rstReadData", bus.read_data, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, lat, rdata);
    checkOutput("wrLatency", 32'(lat), 32'd5);
    checkOutput("wrMemLo", 32'(mem[0]), 32'h0000BEEF);
    checkOutput("wrMemHi", 32'(mem[1]), 32'h0000DEAD);

    applyStimulus(0, 1'b0, 1'b1, 32'd1028, 32'h0, lat, rdata);
    checkOutput("rdLatency", 32'(lat), 32'd5);
    checkOutput("rdData", rdata, 32'h12345678);

    applyStimulus(0, 1'b1, 1'b0, 32'd1032, 32'hCAFEF00D, lat, rdata);
    applyStimulus(0, 1'b0, 1'b1, 32'd1032, 32'h0, lat, rdata);
    checkOutput("b2bLatency", 32'(lat), 32'd5);
    checkOutput("b2bData", rdata, 32'hCAFEF00D);
    checkOutput("b2bMemLo", 32'(mem[4]), 32'h0000F00D);

    applyStimulus(0, 1'b1, 1'b0, 32'd1040, 32'h11112222, lat, rdata);
    checkOutput("holdThroughWrite", bus.read_data, 32'hCAFEF00D);
    checkOutput("holdMemHi", 32'(mem[9]), 32'h00001111);

    bus.rd_en = 1'b1; bus.address = 32'd1024;
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    @(negedge clk);
    checkOutput("dropReadyLow", 32'(bus.ready), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("dropCompleted", bus.read_data, 32'hDEADBEEF);
    checkOutput("dropIdleReady", 32'(bus.ready), 32'd1);

    applyStimulus(0, 1'b0, 1'b1, 32'd1036, 32'h0, lat, rdata);
    checkOutput("buf1Latency", 32'(lat), 32'd5);
    checkOutput("buf1Data", rdata, 32'hCCCCBBBB);
    addrBefore = sramAddr;
    applyStimulus(0, 1'b0, 1'b1, 32'd1036, 32'h0, lat, rdata);
    checkOutput("buf2Data", rdata, 32'hCCCCBBBB);
`ifdef SRAM_CTRL_READ_BUF_EN
    checkOutput("buf2Latency", 32'(lat), 32'd0);
    checkOutput("buf2AddrStill", 32'(sramAddr), 32'(addrBefore));
    applyStimulus(0, 1'b1, 1'b0, 32'd1036, 32'h0F0F1E1E, lat, rdata);
    applyStimulus(0, 1'b0, 1'b1, 32'd1036, 32'h0, lat, rdata);
    checkOutput("bufWrLatency", 32'(lat), 32'd0);
    checkOutput("bufWrData", rdata, 32'h0F0F1E1E);
`else
    checkOutput("buf2Latency", 32'(lat), 32'd5);
    checkOutput("buf2AddrHi", 32'(addrBefore), 32'd7);
`endif

    applyStimulus(1, 1'b0, 1'b1, 32'd1024, 32'h0, lat, rdata);
    checkOutput("w0RdLatency", 32'(lat), 32'd3);
    checkOutput("w0RdData", rdata, 32'h44443333);
    applyStimulus(1, 1'b1, 1'b1, 32'd1028, 32'h9999AAAA, lat, rdata);
    checkOutput("w0BothLatency", 32'(lat), 32'd3);
    checkOutput("w0BothMemLo", 32'(mem0[2]), 32'h0000AAAA);
    checkOutput("w0BothMemHi", 32'(mem0[3]), 32'h00009999);

    bus.wr_en = 1'b1; bus.address = 32'd1048; bus.write_data = 32'hAAAA5555;
    @(posedge clk);
    #1;
    checkOutput("abortWeLow", 32'(weN), 32'd0);
    rst = 1'b0;
    bus.wr_en = 1'b0;
    #1;
    checkOutput("abortWeN", 32'(weN), 32'd1);
    checkOutput("abortOeN", 32'(oeN), 32'd0);
    checkOutput("abortReady", 32'(bus.ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abortNoWrite", 32'(mem[12]), 32'h0);
    applyStimulus(0, 1'b0, 1'b1, 32'd1028, 32'h0, lat, rdata);
    checkOutput("postRstLatency", 32'(lat), 32'd5);
    checkOutput("postRstData", rdata, 32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
